// File: rtl/quad_pkg.sv
// ----------------------------------------------------------------------------
// quad_pkg
//   Definitions shared by the quadrature transmit side (quad_step_gen) and
//   the rotatix decoder that reads it back.
//
//   Contents:
//     DIR_CW / DIR_CCW  direction encoding of a step request
//     phase_t           2-bit quadrature phase (0..3, one step = one lap)
//     state_t           step generator FSM states
//     phase_to_ab()     phase -> {A,B} Gray table
//     phase_step()      advance a phase by one transition in a direction
// ----------------------------------------------------------------------------
package quad_pkg;

    // CW means channel A leads channel B.
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Phase 0 is the detent ({A,B}=00). Walking the phase upwards gives the
    // CW sequence 00->10->11->01->00; walking it downwards gives CCW.
    // Neighbouring phases differ in exactly one bit.
    function automatic logic [1:0] phase_to_ab(input phase_t ph);
        logic [1:0] ab;
        case (ph)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            2'd3:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // One transition: +1 mod 4 for CW, -1 mod 4 for CCW.
    function automatic phase_t phase_step(input phase_t ph, input logic dir);
        phase_t nxt;
        if (dir == DIR_CW) begin
            nxt = ph + 2'd1;
        end else begin
            nxt = ph - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// ----------------------------------------------------------------------------
// quad_edge_timer
//   Loadable down-counter that saturates at zero. Used by the step generator
//   to space quadrature transitions and by the decoder for debounce.
//
//   Ports:
//     clk       in   clock
//     rst_n     in   asynchronous active-low reset (counter clears to 0)
//     load      in   load load_val on this edge (wins over counting)
//     load_val  in   CNT_W value to load
//     expired   out  counter currently reads zero
// ----------------------------------------------------------------------------
module quad_edge_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_ONE;
        end
    end

    // Expiry is seen in the cycle the counter reads zero, so a load of N
    // expires N edges later and a load of 0 expires on the very next edge.
    assign expired = (count_q == '0);

endmodule

// File: rtl/quad_step_gen.sv
// ----------------------------------------------------------------------------
// quad_step_gen
//   Quadrature encoder emulator. Each accepted step command produces one
//   detent of motion: four single-bit {A,B} transitions spaced by the
//   latched period, then one period of hold at the 00 detent.
//
//   Handshake: a step is accepted on a clk edge where step_valid and
//   step_ready are both high. step_dir and period are sampled only on that
//   edge; while a step is in flight step_valid is ignored (no queueing).
//   step_ready is high in IDLE and also in the last hold cycle of a step,
//   so a waiting request is taken on the edge that would end the hold.
//
//   Ports:
//     clk         in   clock
//     rst_n       in   asynchronous active-low reset
//     step_valid  in   step request
//     step_dir    in   1 = CW (A leads B), 0 = CCW
//     step_ready  out  step can be accepted this cycle
//     period      in   clk cycles between transitions (0 behaves as 1)
//     quad_a      out  channel A (registered)
//     quad_b      out  channel B (registered)
//     index       out  position==0 and {A,B}==00
//     position    out  current detent, 0..STEPS_PER_REV-1
//     busy        out  ~step_ready
//     dbg_state   out  FSM state, for observation only
//
//   STEPS_PER_REV must lie in 2..2**POS_W.
// ----------------------------------------------------------------------------
module quad_step_gen
    import quad_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int POS_W         = 8,
    parameter int STEPS_PER_REV = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_valid,
    input  logic             step_dir,
    output logic             step_ready,
    input  logic [CNT_W-1:0] period,
    output logic             quad_a,
    output logic             quad_b,
    output logic             index,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(STEPS_PER_REV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state;
    logic             dir_q;      // direction of the step in flight
    logic [CNT_W-1:0] per_m1;     // latched period minus one
    phase_t           phase;      // 0 at every detent
    logic [1:0]       trans_cnt;  // transitions done in this step, mod 4
    logic             hold;       // all four transitions done, dwelling at 00
    logic [POS_W-1:0] pos_q;
    logic             a_q;
    logic             b_q;

    // ------------------------------------------------------------------
    // Edge timer
    // ------------------------------------------------------------------
    logic             expired;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;

    quad_edge_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (expired)
    );

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic             accept;
    logic             fire;
    logic             hold_done;
    logic [CNT_W-1:0] per_eff_m1;
    phase_t           phase_nxt;
    logic [1:0]       ab_nxt;
    logic [POS_W-1:0] pos_nxt;

    // The hold after the fourth transition has lasted one full period.
    assign hold_done  = (state == ST_RUN) && hold && expired;

    assign step_ready = (state == ST_IDLE) || hold_done;
    assign busy       = ~step_ready;
    assign accept     = step_valid && step_ready;

    // A transition is due once the timer has run down, outside the hold.
    assign fire       = (state == ST_RUN) && !hold && expired;

    // period of 0 is treated as 1, so both give a reload value of 0.
    assign per_eff_m1 = (period == '0) ? '0 : (period - CNT_ONE);

    // Acceptance loads 0 so the first transition lands on the next edge;
    // every transition reloads period-1 so the next one is a period later.
    // accept and fire never coincide: accept inside RUN needs hold=1.
    assign timer_load = accept || fire;
    assign timer_val  = accept ? '0 : per_m1;

    assign phase_nxt  = phase_step(phase, dir_q);
    assign ab_nxt     = phase_to_ab(phase_nxt);

    always_comb begin
        pos_nxt = pos_q;
        if (dir_q == DIR_CW) begin
            pos_nxt = (pos_q == POS_LAST) ? '0 : (pos_q + POS_ONE);
        end else begin
            pos_nxt = (pos_q == '0) ? POS_LAST : (pos_q - POS_ONE);
        end
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dir_q     <= DIR_CW;
            per_m1    <= '0;
            phase     <= '0;
            trans_cnt <= '0;
            hold      <= 1'b0;
            pos_q     <= '0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
        end else begin
            if (accept) begin
                // From IDLE, or back-to-back from the final hold cycle.
                state     <= ST_RUN;
                dir_q     <= step_dir;
                per_m1    <= per_eff_m1;
                trans_cnt <= '0;
                hold      <= 1'b0;
            end else if (fire) begin
                phase       <= phase_nxt;
                {a_q, b_q}  <= ab_nxt;
                trans_cnt   <= trans_cnt + 2'd1;
                if (trans_cnt == 2'd3) begin
                    // Fourth transition: back at the detent, the position
                    // moves on the same edge.
                    hold  <= 1'b1;
                    pos_q <= pos_nxt;
                end
            end else if (hold_done) begin
                state <= ST_IDLE;
                hold  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign quad_a    = a_q;
    assign quad_b    = b_q;
    assign position  = pos_q;
    assign dbg_state = state;

    // Decoded purely from registers, so it only changes just after a clk edge.
    assign index     = (pos_q == '0) && !a_q && !b_q;

endmodule

// File: tb/tb_quad_step_gen.sv
module tb_quad_step_gen;
  import quad_pkg::*;

  localparam int CNT_W = 16;
  localparam int POS_W = 8;
  localparam int SPR   = 24;
  localparam int TMO   = 200;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             step_valid = 1'b0;
  logic             step_dir = 1'b0;
  logic [CNT_W-1:0] period = '0;
  logic             step_ready;
  logic             quad_a;
  logic             quad_b;
  logic             index;
  logic [POS_W-1:0] position;
  logic             busy;
  state_t           dbg_state;

  quad_step_gen #(
    .CNT_W         (CNT_W),
    .POS_W         (POS_W),
    .STEPS_PER_REV (SPR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .period     (period),
    .quad_a     (quad_a),
    .quad_b     (quad_b),
    .index      (index),
    .position   (position),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    int               edge_no;
    logic [1:0]       ab;
    logic [POS_W-1:0] pos;
  } tr_t;

  tr_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int model_pos = 0;
  int last_k = 0;
  int last_p = 1;

  logic [1:0] seq_cw [4];
  logic [1:0] seq_ccw[4];

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: got no response within %0d cycles, expected one", name, TMO);
  endtask

  // Expected transitions of one step accepted at edge k.
  task automatic push_step(input logic dir, input int per, input int k);
    int p;
    int newpos;
    tr_t e;
    p = (per == 0) ? 1 : per;
    newpos = dir ? (model_pos + 1) % SPR : (model_pos + SPR - 1) % SPR;
    for (int i = 0; i < 4; i++) begin
      e.edge_no = k + 1 + i * p;
      e.ab      = dir ? seq_cw[i] : seq_ccw[i];
      e.pos     = POS_W'((i == 3) ? newpos : model_pos);
      exp_q.push_back(e);
    end
    model_pos = newpos;
    last_k = k;
    last_p = p;
  endtask

  // Monitor: every A/B change must be Gray-legal and match the queue head.
  logic [1:0] ab_prev = 2'b00;
  always @(negedge clk) begin
    logic [1:0] ab_now;
    tr_t e;
    ab_now = {quad_a, quad_b};
    if (rst_n && (ab_now != ab_prev)) begin
      check("gray_step", $countones(ab_now ^ ab_prev), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_transition: got ab=%b at edge %0d, expected none", ab_now, cyc);
      end else begin
        e = exp_q.pop_front();
        check("tr_edge", cyc, e.edge_no);
        check("tr_ab", ab_now, e.ab);
        check("tr_pos", position, e.pos);
        check("tr_index", index, (e.pos == 0 && e.ab == 2'b00) ? 1 : 0);
      end
    end
    ab_prev = ab_now;
  end

  // ---------------- driver tasks ----------------
  task automatic do_step(input logic dir, input int per);
    int t;
    @(negedge clk);
    step_valid = 1'b1;
    step_dir   = dir;
    period     = CNT_W'(per);
    t = 0;
    while (!step_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (!step_ready) begin
      timeout_fail("accept_wait");
      step_valid = 1'b0;
      return;
    end
    push_step(dir, per, cyc + 1);
    @(negedge clk);
    // Disturb the inputs while the step is in flight.
    step_valid = 1'b0;
    step_dir   = ~dir;
    period     = CNT_W'($urandom_range(0, 20));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!step_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (!step_ready) begin
      timeout_fail("idle_wait");
      exp_q.delete();
      return;
    end
    check("ready_edge", cyc, last_k + 4 * last_p);
    check("busy_when_ready", busy, 0);
    #1;
    check("sb_drained", exp_q.size(), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic dir;
    int   per;
    int   exp_pos;
    logic exp_idx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int prev_k;
    logic d;

    seq_cw[0]  = 2'b10; seq_cw[1]  = 2'b11; seq_cw[2]  = 2'b01; seq_cw[3]  = 2'b00;
    seq_ccw[0] = 2'b01; seq_ccw[1] = 2'b11; seq_ccw[2] = 2'b10; seq_ccw[3] = 2'b00;

    vecs[0] = '{1'b1, 3, 1,  1'b0};
    vecs[1] = '{1'b0, 1, 0,  1'b1};
    vecs[2] = '{1'b0, 0, 23, 1'b0};
    vecs[3] = '{1'b1, 0, 0,  1'b1};
    vecs[4] = '{1'b1, 7, 1,  1'b0};
    vecs[5] = '{1'b0, 2, 0,  1'b1};

    // 1) reset state, then idle
    #2 rst_n = 1'b0;
    #2;
    check("rst_ab", {quad_a, quad_b}, 2'b00);
    check("rst_pos", position, 0);
    check("rst_index", index, 1);
    check("rst_ready", step_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_ab", {quad_a, quad_b}, 2'b00);
    check("idle_pos", position, 0);
    check("idle_index", index, 1);
    check("idle_ready", step_ready, 1);
    check("idle_state", dbg_state, ST_IDLE);

    // 2,3) table of single steps
    for (int i = 0; i < 6; i++) begin
      do_step(vecs[i].dir, vecs[i].per);
      wait_idle();
      check("vec_pos", position, vecs[i].exp_pos);
      check("vec_index", index, vecs[i].exp_idx);
      check("vec_state", dbg_state, ST_RUN);
    end

    // 4) full revolution CW
    for (int s = 0; s < SPR; s++) begin
      do_step(DIR_CW, 2);
      wait_idle();
      check("rev_index", index, (s == SPR - 1) ? 1 : 0);
    end
    check("rev_pos", position, 0);

    // 5) valid held high, direction alternating, inputs churned mid-step
    @(negedge clk);
    step_valid = 1'b1;
    prev_k = 0;
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0);
      t = 0;
      while (!step_ready && t < TMO) begin
        step_dir = 1'($urandom_range(0, 1));
        period   = CNT_W'($urandom_range(0, 15));
        @(negedge clk);
        t++;
      end
      if (!step_ready) begin
        timeout_fail("b2b_accept");
        break;
      end
      step_dir = d;
      period   = CNT_W'(2);
      if (i > 0) check("b2b_spacing", cyc + 1 - prev_k, 4 * 2 + 1);
      prev_k = cyc + 1;
      push_step(d, 2, cyc + 1);
      @(negedge clk);
    end
    step_valid = 1'b0;
    wait_idle();
    check("b2b_pos", position, 0);

    // 6) reset after the 2nd transition of a step
    do_step(DIR_CW, 2);
    wait_idle();
    check("pre_pos", position, 1);
    do_step(DIR_CW, 4);
    t = 0;
    while (exp_q.size() > 2 && t < TMO) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (exp_q.size() > 2) timeout_fail("mid_step_wait");
    check("mid_ab", {quad_a, quad_b}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ab", {quad_a, quad_b}, 2'b00);
    check("arst_pos", position, 0);
    check("arst_index", index, 1);
    check("arst_ready", step_ready, 1);
    check("arst_state", dbg_state, ST_IDLE);
    exp_q.delete();
    model_pos = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_step(DIR_CW, 1);
    wait_idle();
    check("post_pos", position, 1);
    check("post_index", index, 0);

    repeat (3) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
